// File: rtl/seq_divider_if.sv
// Execute-stage divide handshake between the mul/div unit (master) and the
// sequential divider (slave).
//
// Handshake: the master raises start_i with a non-zero one-hot op_i and
// holds start_i, op_i and the operands until the cycle in which ready_o is
// high. ready_o is a one-cycle pulse, and result_o is valid only in that
// cycle; at all other times result_o is zero. Dropping start_i before
// ready_o abandons the operation, and no pulse follows. If start_i is still
// high after the pulse, a new operation starts from whatever is on the
// inputs at that time.
interface seq_divider_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            start_i;
  logic [3:0]      op_i;      // one-hot {div, divu, rem, remu}
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            busy_o;

  modport master (
    output dividend_i, divisor_i, start_i, op_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  dividend_i, divisor_i, start_i, op_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It divides operand magnitudes over XLEN iterations. A final CALC cycle
// applies the sign fixup. Divide-by-zero and signed overflow complete on
// the accept edge.
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_if.slave       bus,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             q_neg_q, q_neg_d;     // quotient is negated for div
  logic             r_neg_q, r_neg_d;     // remainder takes dividend sign
  logic [XLEN-1:0]  divisor_q, divisor_d; // divisor magnitude
  logic [XLEN-1:0]  rem_q, rem_d;         // partial remainder
  logic [XLEN-1:0]  quo_q, quo_d;         // dividend shifts out, quotient shifts in
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  // Working values for accept and iteration
  logic             acc_signed;
  logic             acc_is_rem;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN:0]    rem_sh;
  logic             sub_ok;
  logic [XLEN-1:0]  sub_lo;
  logic [XLEN-1:0]  fixed_result;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = '0;
    ready_d    = 1'b0;

    acc_signed = bus.op_i[3] | bus.op_i[1];
    acc_is_rem = bus.op_i[1] | bus.op_i[0];
    a_neg      = acc_signed & bus.dividend_i[XLEN-1];
    b_neg      = acc_signed & bus.divisor_i[XLEN-1];

    // One restoring step: shift {rem, quo} left, then trial-subtract.
    // The result of a successful subtract is below the divisor, so the low
    // XLEN bits of the difference hold all of it.
    rem_sh     = {rem_q, quo_q[XLEN-1]};
    sub_ok     = (rem_sh >= {1'b0, divisor_q});
    sub_lo     = rem_sh[XLEN-1:0] - divisor_q;

    if (op_q[3])      fixed_result = q_neg_q ? -quo_q : quo_q;
    else if (op_q[2]) fixed_result = quo_q;
    else if (op_q[1]) fixed_result = r_neg_q ? -rem_q : rem_q;
    else if (op_q[0]) fixed_result = rem_q;
    else              fixed_result = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && (bus.op_i != 4'b0000)) begin
          op_d      = bus.op_i;
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          quo_d     = a_neg ? -bus.dividend_i : bus.dividend_i;
          divisor_d = b_neg ? -bus.divisor_i  : bus.divisor_i;
          rem_d     = '0;
          cnt_d     = '0;
          if (bus.divisor_i == '0) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = acc_is_rem ? bus.dividend_i : '1;
          end else if (acc_signed && (bus.dividend_i == MIN_NEG) &&
                       (bus.divisor_i == '1)) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = acc_is_rem ? '0 : MIN_NEG;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!bus.start_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          result_d = fixed_result;
        end else begin
          rem_d = sub_ok ? sub_lo : rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], sub_ok};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers, all cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed RV32M cases, abort, reset and randomized
// operations against an arithmetic reference model.
module tb_seq_divider;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0010;
  localparam logic [3:0] OP_REMU = 4'b0001;
  localparam int LAT_FULL = 34;
  localparam int LAT_FAST = 1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       prev_ready;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  seq_divider_if #(.XLEN(32)) bus ();

  seq_divider #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 32'd0) begin
      r = (op == OP_DIV || op == OP_DIVU) ? longint'(32'hFFFF_FFFF) : ua;
    end else begin
      case (op)
        OP_DIV:  r = sa / sb;
        OP_REM:  r = sa % sb;
        OP_DIVU: r = ua / ub;
        default: r = ua % ub;
      endcase
    end
    return r[31:0];
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return LAT_FAST;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return LAT_FAST;
    return LAT_FULL;
  endfunction

  // ---------------- driver ----------------
  // Drives one operation from a negedge and waits for the ready pulse.
  // lat counts cycles from the drive point up to and including the ready cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit keep,
                        input string tag);
    int cyc;
    exp_q.push_back(exp);
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.ready_o) check({tag, "_res_zero"}, bus.result_o, 32'd0);
    end while (!bus.ready_o && cyc < 200);
    check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_result"}, bus.result_o, exp_q.pop_front());
    if (!keep) begin
      bus.start_i = 1'b0;
      @(negedge clk);
      check({tag, "_after_ready"}, 32'(bus.ready_o), 32'd0);
      check({tag, "_after_busy"}, 32'(bus.busy_o), 32'd0);
    end
  endtask

  // ---------------- protocol monitors ----------------
  always @(negedge clk) begin
    check("ready_two_cycles", 32'(bus.ready_o && prev_ready), 32'd0);
    check("op_onehot", 32'(bus.start_i && ($countones(bus.op_i) > 1)), 32'd0);
    prev_ready = bus.ready_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    int          pick;

    prev_ready     = 1'b0;
    bus.start_i    = 1'b0;
    bus.op_i       = 4'b0000;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    rst            = 1'b1;
    #1;
    check("reset_ready", 32'(bus.ready_o), 32'd0);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic
    run_op(OP_DIV,  32'd100,        32'd7,          32'd14,         LAT_FULL, 1'b0, "div_100_7");
    run_op(OP_REM,  32'd100,        32'd7,          32'd2,          LAT_FULL, 1'b0, "rem_100_7");
    run_op(OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  LAT_FULL, 1'b0, "div_m100_7");
    run_op(OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  LAT_FULL, 1'b0, "rem_m100_7");
    run_op(OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          LAT_FULL, 1'b0, "rem_100_m7");
    run_op(OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  LAT_FULL, 1'b0, "divu_max_2");
    run_op(OP_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1,          LAT_FULL, 1'b0, "remu_max_2");

    // Divide by zero fast path
    run_op(OP_DIV,  32'h1234_5678,  32'd0, 32'hFFFF_FFFF, LAT_FAST, 1'b0, "div_by0");
    run_op(OP_DIVU, 32'h1234_5678,  32'd0, 32'hFFFF_FFFF, LAT_FAST, 1'b0, "divu_by0");
    run_op(OP_REM,  32'h1234_5678,  32'd0, 32'h1234_5678, LAT_FAST, 1'b0, "rem_by0");
    run_op(OP_REMU, 32'h1234_5678,  32'd0, 32'h1234_5678, LAT_FAST, 1'b0, "remu_by0");
    run_op(OP_REM,  32'h8000_0001,  32'd0, 32'h8000_0001, LAT_FAST, 1'b0, "rem_neg_by0");

    // Signed overflow fast path; unsigned version takes the normal path
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST, 1'b0, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_FAST, 1'b0, "rem_ovf");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_FULL, 1'b0, "divu_nonovf");

    // op_i = 0 is never accepted
    bus.op_i    = 4'b0000;
    bus.start_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("op0_busy", 32'(bus.busy_o), 32'd0);
      check("op0_ready", 32'(bus.ready_o), 32'd0);
    end
    bus.start_i = 1'b0;
    @(negedge clk);

    // Back-to-back: start_i held through the ready cycle with new inputs
    run_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, LAT_FULL,     1'b1, "b2b_first");
    run_op(OP_REMU, 32'd1000, 32'd7,  32'd6,   LAT_FULL + 1, 1'b0, "b2b_second");

    // Abort mid-calculation, then a clean restart
    bus.op_i       = OP_DIV;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    bus.start_i    = 1'b1;
    repeat (11) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy_o), 32'd1);
    bus.start_i = 1'b0;
    bus.dividend_i = 32'd77;   // changes after abort must not matter
    repeat (4) begin
      @(negedge clk);
      check("abort_busy", 32'(bus.busy_o), 32'd0);
      check("abort_ready", 32'(bus.ready_o), 32'd0);
      check("abort_result", bus.result_o, 32'd0);
    end
    run_op(OP_DIV, 32'd9, 32'd3, 32'd3, LAT_FULL, 1'b0, "restart_9_3");

    // Reset in the middle of an operation
    bus.op_i       = OP_DIV;
    bus.dividend_i = 32'd1234;
    bus.divisor_i  = 32'd5;
    bus.start_i    = 1'b1;
    repeat (21) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready_o), 32'd0);
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("postrst_ready", 32'(bus.ready_o), 32'd0);
      check("postrst_busy", 32'(bus.busy_o), 32'd0);
    end
    run_op(OP_DIV, 32'd50, 32'd5, 32'd10, LAT_FULL, 1'b0, "postrst_50_5");

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      r_op = 4'b0001 << $urandom_range(0, 3);
      r_a  = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = -32'($urandom_range(1, 15));
        3: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        4:       r_b = r_a;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), model_lat(r_op, r_a, r_b), 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
